mips_pipe_core: RTL and testbench

Parametrised single-clock 5-stage (IF/ID/EX/MEM/WB) integer pipeline, successor to the two-phase MIPS32 core. It generalises data width and register count and moves instruction and data memory outside the core. It adds full-rate operation with EX-stage forwarding, load-use interlock, branch flush and halt drain. It sits between an external instruction ROM and a data RAM, both with combinational reads.

---
 rtl/mips_pkg.sv | 65 ++++++
 rtl/mips_regfile.sv | 37 +++
 rtl/mips_pipe_core.sv | 252 +++++++++++++++++++++++++
 tb/tb_mips_pipe_core.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared opcodes, instruction classes and field/decode helpers for the mips_pipe_core pipeline.
package mips_pkg;

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_SLT   = 6'h04;
  localparam logic [5:0] OP_MUL   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h08;
  localparam logic [5:0] OP_SW    = 6'h09;
  localparam logic [5:0] OP_ADDI  = 6'h0A;
  localparam logic [5:0] OP_SUBI  = 6'h0B;
  localparam logic [5:0] OP_SLTI  = 6'h0C;
  localparam logic [5:0] OP_BNEQZ = 6'h0D;
  localparam logic [5:0] OP_BEQZ  = 6'h0E;
  localparam logic [5:0] OP_HLT   = 6'h3F;

  typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT} instr_cls_e;

  function automatic logic [5:0] f_opcode(input logic [31:0] ir);
    return ir[31:26];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] ir);
    return ir[25:21];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] ir);
    return ir[20:16];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] ir);
    return ir[15:11];
  endfunction

  function automatic logic [15:0] f_imm(input logic [31:0] ir);
    return ir[15:0];
  endfunction

  // Unknown opcodes fall into HALT.
  function automatic instr_cls_e decode_cls(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                    return RM_ALU;
      OP_LW:                                        return LOAD;
      OP_SW:                                        return STORE;
      OP_BNEQZ, OP_BEQZ:                            return BRANCH;
      default:                                      return HALT;
    endcase
  endfunction

  function automatic logic reads_rs(input instr_cls_e cls);
    return cls != HALT;
  endfunction

  function automatic logic reads_rt(input instr_cls_e cls);
    return (cls == RR_ALU) || (cls == STORE);
  endfunction

  function automatic logic writes_rf(input instr_cls_e cls);
    return (cls == RR_ALU) || (cls == RM_ALU) || (cls == LOAD);
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// NREG x XLEN register file, two read ports, one write port, r0 hardwired to zero, write-through.
module mips_regfile #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned RW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RW-1:0]   raddr_a,
  input  logic [RW-1:0]   raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b,
  input  logic            we,
  input  logic [RW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs_q [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = regs_q[raddr_a];
    rdata_b = regs_q[raddr_b];
    if (we && (waddr == raddr_a)) rdata_a = wdata;
    if (we && (waddr == raddr_b)) rdata_b = wdata;
    if (raddr_a == '0) rdata_a = '0;
    if (raddr_b == '0) rdata_b = '0;
  end

endmodule

// File: rtl/mips_pipe_core.sv
// Five-stage IF/ID/EX/MEM/WB integer pipeline with external instruction ROM and data RAM.
// Define MIPS_FWD_EN to build EX-stage bypass paths; otherwise dependent instructions stall in ID.
module mips_pipe_core
  import mips_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned IAW  = 10,
  parameter int unsigned DAW  = 10
) (
  input  logic            clk,
  input  logic            rst,
  output logic [IAW-1:0]  imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [DAW-1:0]  dmem_addr,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            retire_valid,
  output logic            halted
);

  localparam int unsigned RW = $clog2(NREG);

  logic           halted_q, fetch_stop_q;
  logic [IAW-1:0] pc_q, pc_d;

  logic           ifid_valid_q;
  logic [31:0]    ifid_ir_q;
  logic [IAW-1:0] ifid_npc_q;

  logic            idex_valid_q, idex_we_q;
  instr_cls_e      idex_cls_q;
  logic [5:0]      idex_op_q;
  logic [XLEN-1:0] idex_a_q, idex_b_q, idex_imm_q;
  logic [RW-1:0]   idex_dst_q;
  logic [IAW-1:0]  idex_npc_q;
`ifdef MIPS_FWD_EN
  logic [RW-1:0]   idex_rs_q, idex_rt_q;
`endif

  logic            exmem_valid_q, exmem_we_q;
  instr_cls_e      exmem_cls_q;
  logic [XLEN-1:0] exmem_alu_q, exmem_b_q;
  logic [RW-1:0]   exmem_dst_q;

  logic            memwb_valid_q, memwb_we_q, memwb_halt_q;
  logic [XLEN-1:0] memwb_res_q;
  logic [RW-1:0]   memwb_dst_q;

  // ID: decode and register read
  logic [5:0]      id_op;
  instr_cls_e      id_cls;
  logic [4:0]      id_rs5, id_rt5, id_rd5;
  logic [RW-1:0]   id_rs, id_rt, id_dst;
  logic [XLEN-1:0] id_a, id_b, id_imm;
  logic            id_we, id_use_rs, id_use_rt;

  assign id_op     = f_opcode(ifid_ir_q);
  assign id_cls    = decode_cls(id_op);
  assign id_rs5    = f_rs(ifid_ir_q);
  assign id_rt5    = f_rt(ifid_ir_q);
  assign id_rd5    = f_rd(ifid_ir_q);
  assign id_rs     = id_rs5[RW-1:0];
  assign id_rt     = id_rt5[RW-1:0];
  assign id_dst    = (id_cls == RR_ALU) ? id_rd5[RW-1:0] : id_rt;
  assign id_we     = writes_rf(id_cls) && (id_dst != '0);
  assign id_imm    = {{(XLEN-16){ifid_ir_q[15]}}, f_imm(ifid_ir_q)};
  assign id_use_rs = ifid_valid_q && reads_rs(id_cls);
  assign id_use_rt = ifid_valid_q && reads_rt(id_cls);

  logic rf_we;
  assign rf_we = memwb_valid_q && memwb_we_q && !halted_q;

  mips_regfile #(
    .XLEN (XLEN),
    .NREG (NREG),
    .RW   (RW)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (id_rs),
    .raddr_b (id_rt),
    .rdata_a (id_a),
    .rdata_b (id_b),
    .we      (rf_we),
    .waddr   (memwb_dst_q),
    .wdata   (memwb_res_q)
  );

  // Hazard detection; destination r0 never counts as a producer since *_we excludes it.
  logic ex_dep, stall, flush, id_halt;
  assign ex_dep = idex_valid_q && idex_we_q &&
                  ((id_use_rs && (idex_dst_q == id_rs)) || (id_use_rt && (idex_dst_q == id_rt)));
`ifdef MIPS_FWD_EN
  assign stall = !flush && ex_dep && (idex_cls_q == LOAD);
`else
  logic mem_dep;
  assign mem_dep = exmem_valid_q && exmem_we_q &&
                   ((id_use_rs && (exmem_dst_q == id_rs)) || (id_use_rt && (exmem_dst_q == id_rt)));
  assign stall = !flush && (ex_dep || mem_dep);
`endif
  assign id_halt = ifid_valid_q && (id_cls == HALT) && !flush;

  // EX operands
  logic [XLEN-1:0] ex_a, ex_b, ex_alu;
`ifdef MIPS_FWD_EN
  always_comb begin
    ex_a = idex_a_q;
    ex_b = idex_b_q;
    if (exmem_valid_q && exmem_we_q && (exmem_cls_q != LOAD) && (exmem_dst_q == idex_rs_q)) begin
      ex_a = exmem_alu_q;
    end else if (memwb_valid_q && memwb_we_q && (memwb_dst_q == idex_rs_q)) begin
      ex_a = memwb_res_q;
    end
    if (exmem_valid_q && exmem_we_q && (exmem_cls_q != LOAD) && (exmem_dst_q == idex_rt_q)) begin
      ex_b = exmem_alu_q;
    end else if (memwb_valid_q && memwb_we_q && (memwb_dst_q == idex_rt_q)) begin
      ex_b = memwb_res_q;
    end
  end
`else
  assign ex_a = idex_a_q;
  assign ex_b = idex_b_q;
`endif

  always_comb begin
    ex_alu = '0;
    case (idex_cls_q)
      RR_ALU: begin
        case (idex_op_q)
          OP_ADD:  ex_alu = ex_a + ex_b;
          OP_SUB:  ex_alu = ex_a - ex_b;
          OP_AND:  ex_alu = ex_a & ex_b;
          OP_OR:   ex_alu = ex_a | ex_b;
          OP_SLT:  ex_alu = {{(XLEN-1){1'b0}}, (ex_a < ex_b)};
          OP_MUL:  ex_alu = ex_a * ex_b;
          default: ex_alu = '0;
        endcase
      end
      RM_ALU: begin
        case (idex_op_q)
          OP_ADDI: ex_alu = ex_a + idex_imm_q;
          OP_SUBI: ex_alu = ex_a - idex_imm_q;
          OP_SLTI: ex_alu = {{(XLEN-1){1'b0}}, (ex_a < idex_imm_q)};
          default: ex_alu = '0;
        endcase
      end
      LOAD, STORE: ex_alu = ex_a + idex_imm_q;
      default:     ex_alu = '0;
    endcase
  end

  logic           br_zero;
  logic [IAW-1:0] br_target;
  assign br_zero   = (ex_a == '0);
  assign br_target = idex_npc_q + idex_imm_q[IAW-1:0];
  assign flush     = idex_valid_q && (idex_cls_q == BRANCH) &&
                     ((idex_op_q == OP_BEQZ) ? br_zero : !br_zero);

  always_comb begin
    if (flush)                                pc_d = br_target;
    else if (stall || id_halt || fetch_stop_q) pc_d = pc_q;
    else                                      pc_d = pc_q + IAW'(1);
  end

  // MEM
  logic [XLEN-1:0] mem_res;
  assign mem_res = (exmem_cls_q == LOAD) ? dmem_rdata : exmem_alu_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_q      <= 1'b0;
      fetch_stop_q  <= 1'b0;
      pc_q          <= '0;
      ifid_valid_q  <= 1'b0;
      ifid_ir_q     <= '0;
      ifid_npc_q    <= '0;
      idex_valid_q  <= 1'b0;
      idex_we_q     <= 1'b0;
      idex_cls_q    <= RR_ALU;
      idex_op_q     <= '0;
      idex_a_q      <= '0;
      idex_b_q      <= '0;
      idex_imm_q    <= '0;
      idex_dst_q    <= '0;
      idex_npc_q    <= '0;
`ifdef MIPS_FWD_EN
      idex_rs_q     <= '0;
      idex_rt_q     <= '0;
`endif
      exmem_valid_q <= 1'b0;
      exmem_we_q    <= 1'b0;
      exmem_cls_q   <= RR_ALU;
      exmem_alu_q   <= '0;
      exmem_b_q     <= '0;
      exmem_dst_q   <= '0;
      memwb_valid_q <= 1'b0;
      memwb_we_q    <= 1'b0;
      memwb_halt_q  <= 1'b0;
      memwb_res_q   <= '0;
      memwb_dst_q   <= '0;
    end else if (!halted_q) begin
      halted_q     <= memwb_valid_q && memwb_halt_q;
      fetch_stop_q <= fetch_stop_q || id_halt;
      pc_q         <= pc_d;

      if (flush) begin
        ifid_valid_q <= 1'b0;
      end else if (!stall) begin
        ifid_valid_q <= !(id_halt || fetch_stop_q);
        ifid_ir_q    <= imem_rdata;
        ifid_npc_q   <= pc_q + IAW'(1);
      end

      idex_valid_q <= ifid_valid_q && !flush && !stall;
      idex_we_q    <= id_we;
      idex_cls_q   <= id_cls;
      idex_op_q    <= id_op;
      idex_a_q     <= id_a;
      idex_b_q     <= id_b;
      idex_imm_q   <= id_imm;
      idex_dst_q   <= id_dst;
      idex_npc_q   <= ifid_npc_q;
`ifdef MIPS_FWD_EN
      idex_rs_q    <= id_rs;
      idex_rt_q    <= id_rt;
`endif

      exmem_valid_q <= idex_valid_q;
      exmem_we_q    <= idex_we_q;
      exmem_cls_q   <= idex_cls_q;
      exmem_alu_q   <= ex_alu;
      exmem_b_q     <= ex_b;
      exmem_dst_q   <= idex_dst_q;

      memwb_valid_q <= exmem_valid_q;
      memwb_we_q    <= exmem_we_q;
      memwb_halt_q  <= (exmem_cls_q == HALT);
      memwb_res_q   <= mem_res;
      memwb_dst_q   <= exmem_dst_q;
    end
  end

  assign imem_addr    = pc_q;
  assign dmem_addr    = exmem_alu_q[DAW-1:0];
  assign dmem_wdata   = exmem_b_q;
  assign dmem_we      = exmem_valid_q && (exmem_cls_q == STORE) && !halted_q;
  assign retire_valid = memwb_valid_q && !halted_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_mips_pipe_core.sv
// Directed self-checking bench for mips_pipe_core; expectations follow the MIPS_FWD_EN build setting.
module tb_mips_pipe_core;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [9:0]  dmem_addr;
  logic        dmem_we;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        retire_valid;
  logic        halted;

  logic [31:0] imem [1024];
  logic [31:0] dmem [1024];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ret_cnt, we_cnt, hc;
  logic [63:0] ret_mask;
  logic [31:0] we_addr, we_data;

`ifdef MIPS_FWD_EN
  localparam int H1 = 8, H2 = 10, H4 = 12;
`else
  localparam int H1 = 10, H2 = 13, H4 = 14;
`endif

  mips_pipe_core u_dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .dmem_addr    (dmem_addr),
    .dmem_we      (dmem_we),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .retire_valid (retire_valid),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];
  always @(posedge clk) if (dmem_we) dmem[dmem_addr] <= dmem_wdata;

  always @(negedge clk) begin
    if (!rst) begin
      if (retire_valid) begin
        ret_cnt++;
        if (cyc < 64) ret_mask[cyc] = 1'b1;
      end
      if (dmem_we) begin
        we_cnt++;
        we_addr = 32'(dmem_addr);
        we_data = dmem_wdata;
      end
    end
  end

  function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs,
                                     input int rt);
    return {op, rs[4:0], rt[4:0], rd[4:0], 11'b0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs,
                                     input int imm);
    return {op, rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] rf(input int i);
    return u_dut.u_rf.regs_q[i];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      imem[i] = {OP_HLT, 26'b0};
      dmem[i] = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ret_cnt  = 0;
    we_cnt   = 0;
    ret_mask = '0;
    we_addr  = '0;
    we_data  = '0;
    cyc      = 0;
    rst      = 1'b0;
  endtask

  task automatic run_to_halt(output int h);
    h = -1;
    for (int i = 0; i < 80; i++) begin
      step();
      if (halted) begin
        h = cyc;
        break;
      end
    end
  endtask

  initial begin
    // Reset state
    clear_mem();
    rst = 1'b1;
    #12;
    chk("rst_imem_addr", 32'(imem_addr), 0);
    chk("rst_retire", 32'(retire_valid), 0);
    chk("rst_dmem_we", 32'(dmem_we), 0);
    chk("rst_dmem_addr", 32'(dmem_addr), 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);
    chk("rst_halted", 32'(halted), 0);

    // Forwarded arithmetic chain
    clear_mem();
    imem[0] = ri(OP_ADDI, 1, 0, 5);
    imem[1] = ri(OP_ADDI, 2, 0, 7);
    imem[2] = rr(OP_ADD, 3, 1, 2);
    do_reset();
    run_to_halt(hc);
    chk("t1_halt_cycle", hc, H1);
    chk("t1_r3", rf(3), 12);
    chk("t1_retires", ret_cnt, 4);

    // Store, load, load-use
    clear_mem();
    imem[0] = ri(OP_ADDI, 1, 0, 9);
    imem[1] = ri(OP_SW, 1, 0, 3);
    imem[2] = ri(OP_LW, 4, 0, 3);
    imem[3] = rr(OP_ADD, 5, 4, 4);
    do_reset();
    run_to_halt(hc);
    chk("t2_halt_cycle", hc, H2);
    chk("t2_we_count", we_cnt, 1);
    chk("t2_we_addr", we_addr, 3);
    chk("t2_we_data", we_data, 9);
    chk("t2_mem3", dmem[3], 9);
    chk("t2_r4", rf(4), 9);
    chk("t2_r5", rf(5), 18);

    // Taken branch flushes two slots
    clear_mem();
    imem[0] = ri(OP_BEQZ, 0, 0, 2);
    imem[1] = ri(OP_ADDI, 6, 0, 1);
    imem[2] = ri(OP_ADDI, 6, 0, 2);
    imem[3] = ri(OP_ADDI, 7, 0, 3);
    do_reset();
    run_to_halt(hc);
    chk("t3_halt_cycle", hc, 9);
    chk("t3_r6", rf(6), 0);
    chk("t3_r7", rf(7), 3);
    chk("t3_retires", ret_cnt, 3);
    chk("t3_retire_mask", 32'(ret_mask[8:4]), 32'b11001);

    // Not-taken branch, no penalty
    imem[0] = ri(OP_BNEQZ, 0, 0, 2);
    do_reset();
    run_to_halt(hc);
    chk("t3n_halt_cycle", hc, 9);
    chk("t3n_r6", rf(6), 2);
    chk("t3n_r7", rf(7), 3);
    chk("t3n_retires", ret_cnt, 5);

    // Back-to-back dependency
    clear_mem();
    imem[0] = ri(OP_ADDI, 8, 0, 6);
    imem[1] = ri(OP_ADDI, 9, 0, 5);
    imem[2] = rr(OP_ADD, 10, 0, 0);
    imem[3] = rr(OP_ADD, 11, 0, 0);
    imem[4] = rr(OP_ADD, 1, 8, 9);
    imem[5] = rr(OP_SUB, 2, 1, 1);
    imem[6] = rr(OP_SUB, 3, 1, 8);
    do_reset();
    run_to_halt(hc);
    chk("t4_halt_cycle", hc, H4);
    chk("t4_r1", rf(1), 11);
    chk("t4_r2", rf(2), 0);
    chk("t4_r3", rf(3), 5);

    // Reset while a store sits in MEM
    clear_mem();
    imem[0] = ri(OP_ADDI, 1, 0, 9);
    imem[1] = rr(OP_ADD, 10, 0, 0);
    imem[2] = rr(OP_ADD, 11, 0, 0);
    imem[3] = ri(OP_SW, 1, 0, 5);
    dmem[5] = 32'hAA;
    do_reset();
    repeat (6) step();
    chk("t5_we_before", 32'(dmem_we), 1);
    chk("t5_addr_before", 32'(dmem_addr), 5);
    chk("t5_data_before", dmem_wdata, 9);
    #1 rst = 1'b1;
    #1;
    chk("t5_we_in_rst", 32'(dmem_we), 0);
    chk("t5_pc_in_rst", 32'(imem_addr), 0);
    chk("t5_retire_in_rst", 32'(retire_valid), 0);
    @(posedge clk);
    #1;
    chk("t5_store_dropped", dmem[5], 32'hAA);
    @(negedge clk);
    cyc = 0;
    rst = 1'b0;
    chk("t5_restart_pc", 32'(imem_addr), 0);
    step();
    chk("t5_restart_pc1", 32'(imem_addr), 1);

    // Undefined opcode halts
    clear_mem();
    imem[0] = ri(OP_ADDI, 1, 0, 4);
    imem[1] = 32'h8000_0000;
    imem[2] = ri(OP_ADDI, 2, 0, 7);
    imem[3] = ri(OP_ADDI, 3, 0, 1);
    do_reset();
    run_to_halt(hc);
    chk("t6_halt_cycle", hc, 6);
    repeat (5) step();
    chk("t6_halted_holds", 32'(halted), 1);
    chk("t6_pc_frozen", 32'(imem_addr), 2);
    chk("t6_retire_off", 32'(retire_valid), 0);
    chk("t6_r1", rf(1), 4);
    chk("t6_r2", rf(2), 0);
    chk("t6_r3", rf(3), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
